// File: rtl/layer_sequencer.sv
// Evaluation-window sequencer for one bitstream layer: clear, warm-up, counted
// stream, then hold per-neuron ones counts until the consumer accepts them.

module layer_sequencer_lane #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          stream,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + CW'(stream);
  end
endmodule

module layer_sequencer #(
  parameter  int NEURON_COUNT  = 2,
  parameter  int STREAM_LENGTH = 256,
  parameter  int WARMUP_CYCLES = 2,
  localparam int COUNT_WIDTH   = $clog2(STREAM_LENGTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                layer_clear,
  output logic                                layer_enable,
  input  logic [NEURON_COUNT-1:0]             layer_output,
  output logic [NEURON_COUNT*COUNT_WIDTH-1:0] count_out,
  output logic                                result_valid,
  input  logic                                result_ready
);
  localparam int MAXC = (STREAM_LENGTH > WARMUP_CYCLES) ? STREAM_LENGTH : WARMUP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARMUP, S_RUN, S_HOLD} state_t;

  state_t                                     state;
  logic [TW-1:0]                              timer;
  logic [NEURON_COUNT-1:0][COUNT_WIDTH-1:0]   cnt;
  logic                                       lane_clr;
  logic                                       lane_en;

  // Counters zero on the edge that enters CLEAR and accumulate only in RUN.
  assign lane_clr  = (state == S_IDLE) && start;
  assign lane_en   = (state == S_RUN);
  assign count_out = cnt;

  for (genvar i = 0; i < NEURON_COUNT; i++) begin : g_lane
    layer_sequencer_lane #(.CW(COUNT_WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (lane_clr),
      .en     (lane_en),
      .stream (layer_output[i]),
      .cnt    (cnt[i])
    );
  end

  // One down-counter times both WARMUP and RUN; it is loaded with length-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      busy         <= 1'b0;
      layer_clear  <= 1'b0;
      layer_enable <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state       <= S_CLEAR;
          busy        <= 1'b1;
          layer_clear <= 1'b1;
        end
        S_CLEAR: begin
          layer_clear  <= 1'b0;
          layer_enable <= 1'b1;
          if (WARMUP_CYCLES == 0) begin
            state <= S_RUN;
            timer <= TW'(STREAM_LENGTH - 1);
          end else begin
            state <= S_WARMUP;
            timer <= TW'(WARMUP_CYCLES - 1);
          end
        end
        S_WARMUP: begin
          if (timer == '0) begin
            state <= S_RUN;
            timer <= TW'(STREAM_LENGTH - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_RUN: begin
          if (timer == '0) begin
            state        <= S_HOLD;
            layer_enable <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_HOLD: if (result_ready) begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: table-driven evaluations with a result scoreboard,
// plus reset, mid-run reset and zero-warm-up sequences.

module tb_layer_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start0, ready0, start1, ready1;
  logic [1:0] lo0, lo1;
  logic       busy0, clear0, en0, valid0;
  logic       busy1, clear1, en1, valid1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int total = 0;
  int bad   = 0;
  int sb[$];

  typedef struct {
    logic [1:0] wpat;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [3:0] exp0;
    logic [3:0] exp1;
    int         hold;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  layer_sequencer #(.NEURON_COUNT(2), .STREAM_LENGTH(8), .WARMUP_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .layer_clear(clear0),
    .layer_enable(en0), .layer_output(lo0), .count_out(cnt0),
    .result_valid(valid0), .result_ready(ready0));

  layer_sequencer #(.NEURON_COUNT(2), .STREAM_LENGTH(1), .WARMUP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .layer_clear(clear1),
    .layer_enable(en1), .layer_output(lo1), .count_out(cnt1),
    .result_valid(valid1), .result_ready(ready1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called in an IDLE cycle: this cycle is cycle 0 of the evaluation.
  task automatic run_eval(input vec_t v);
    int cyc;
    int exp;
    bit seen;
    start0 = 1'b1;
    ready0 = 1'b0;
    lo0    = v.wpat;
    sb.push_back(int'({v.exp1, v.exp0}));
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      step();
      cyc++;
      start0 = 1'b0;
      if (valid0) seen = 1'b1;
      else begin
        check("clear_timing", clear0, int'(cyc == 1));
        check("enable_timing", en0, int'(cyc >= 2 && cyc <= 11));
        check("busy_active", busy0, 1);
        lo0 = (cyc >= 4 && cyc <= 11) ? {v.s1[cyc-4], v.s0[cyc-4]} : v.wpat;
      end
    end
    check("valid_cycle", seen ? cyc : -1, 12);
    if (!seen) return;
    exp = sb.pop_front();
    check("count_result", cnt0, exp);
    check("enable_in_hold", en0, 0);
    for (int h = 0; h < v.hold; h++) begin
      ready0 = 1'b0;
      start0 = 1'b1;
      step();
      check("bp_valid", valid0, 1);
      check("bp_count", cnt0, exp);
      check("bp_busy", busy0, 1);
      check("bp_clear", clear0, 0);
    end
    ready0 = 1'b1;
    start0 = 1'b1;
    step();
    ready0 = 1'b0;
    start0 = 1'b0;
    check("accept_busy", busy0, 0);
    check("accept_valid", valid0, 0);
    check("accept_count", cnt0, exp);
    check("accept_clear", clear0, 0);
  endtask

  initial begin
    tbl[0] = '{2'b01, 8'hFF, 8'h00, 4'd8, 4'd0, 0};
    tbl[1] = '{2'b11, 8'h00, 8'h55, 4'd0, 4'd4, 0};
    tbl[2] = '{2'b00, 8'hA5, 8'h3C, 4'd4, 4'd4, 5};
    tbl[3] = '{2'b10, 8'h81, 8'hFE, 4'd2, 4'd7, 1};
    tbl[4] = '{2'b11, 8'hFF, 8'hFF, 4'd8, 4'd8, 0};

    rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
    ready0 = 1'b0; ready1 = 1'b0; lo0 = 2'b11; lo1 = 2'b11;
    for (int r = 0; r < 2; r++) begin
      step();
      check("rst_busy", busy0, 0);
      check("rst_clear", clear0, 0);
      check("rst_enable", en0, 0);
      check("rst_valid", valid0, 0);
      check("rst_count", cnt0, 0);
      check("rst_busy_nw", busy1, 0);
    end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    step();
    check("post_rst_busy", busy0, 0);
    check("post_rst_clear", clear0, 0);

    // Back-to-back: each evaluation starts in the cycle after the handshake.
    for (int i = 0; i < 4; i++) run_eval(tbl[i]);

    // Reset during RUN cycle 4 (cycle 7), after three counted ones.
    start0 = 1'b1;
    lo0    = 2'b11;
    for (int c = 1; c <= 7; c++) begin
      step();
      start0 = 1'b0;
    end
    check("midrun_partial", cnt0, 8'h33);
    check("midrun_enable", en0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_rst_busy", busy0, 0);
    check("midrun_rst_count", cnt0, 0);
    check("midrun_rst_enable", en0, 0);
    check("midrun_rst_valid", valid0, 0);
    run_eval(tbl[4]);

    // Zero warm-up, single-cycle stream.
    start1 = 1'b1;
    lo1    = 2'b10;
    sb.push_back(int'(2'b10));
    step();
    start1 = 1'b0;
    check("nw_clear", clear1, 1);
    check("nw_enable_c1", en1, 0);
    step();
    check("nw_run_enable", en1, 1);
    check("nw_run_clear", clear1, 0);
    check("nw_run_valid", valid1, 0);
    step();
    check("nw_valid", valid1, 1);
    check("nw_enable_hold", en1, 0);
    check("nw_count", cnt1, sb.pop_front());
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    check("nw_accept_busy", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
